// File: rtl/periph_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | periph_regs : UART / LED / interrupt register block, one-cycle reads.    |
// | Interrupt registers built only when PERIPH_REGS_IRQ_EN is defined. Rev 1.0|
// +--------------------------------------------------------------------------+
module periph_regs #(
  parameter int LED_W  = 4,
  parameter int IRQ_N  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_status,
  input  logic [7:0]        uart_rcvd_byte,
  output logic [7:0]        uart_send_byte,
  output logic              uart_send_stb,
  output logic [7:0]        uart_cfg,
  output logic [LED_W-1:0]  led,
  input  logic [IRQ_N-1:0]  irq_src,
  output logic              irq,
  input  logic              wr_en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rdata,
  output logic              rd_rdy
);

  localparam logic [ADDR_W-1:0] ADDR_UART     = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_LED      = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = ADDR_W'(32'h0C);
  localparam logic [7:0]        CFG_RESET     = 8'h06;

  logic              wr_uart, wr_led;
  logic [7:0]        send_q, send_d, cfg_q, cfg_d;
  logic              stb_q, stb_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       bmask, led_full;
  logic [31:0]       rd_val, rdata_q;
  logic              rd_rdy_q;
  logic [IRQ_N-1:0]  stat_rd, en_rd;
  logic              unused_ok;

  assign wr_uart = wr_en && (wr_addr == ADDR_UART);
  assign wr_led  = wr_en && (wr_addr == ADDR_LED);
  assign bmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  always_comb begin
    send_d   = send_q;
    cfg_d    = cfg_q;
    stb_d    = 1'b0;
    led_full = 32'(led_q);
    if (wr_uart && be[1]) begin
      send_d = wdata[15:8];
      stb_d  = 1'b1;
    end
    if (wr_uart && be[3]) cfg_d = wdata[31:24];
    if (wr_led) led_full = (led_full & ~bmask) | (wdata & bmask);
    led_d = led_full[LED_W-1:0];
  end

  // Read mux sees pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (rd_addr)
      ADDR_UART:     rd_val = {cfg_q, uart_rcvd_byte, send_q, uart_status};
      ADDR_LED:      rd_val = 32'(led_q);
      ADDR_IRQ_STAT: rd_val = 32'(stat_rd);
      ADDR_IRQ_EN:   rd_val = 32'(en_rd);
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_q   <= '0;
      cfg_q    <= CFG_RESET;
      stb_q    <= 1'b0;
      led_q    <= '0;
      rdata_q  <= '0;
      rd_rdy_q <= 1'b0;
    end else begin
      send_q   <= send_d;
      cfg_q    <= cfg_d;
      stb_q    <= stb_d;
      led_q    <= led_d;
      rdata_q  <= rd_en ? rd_val : 32'h0;
      rd_rdy_q <= rd_en;
    end
  end

`ifdef PERIPH_REGS_IRQ_EN
  logic [IRQ_N-1:0] hist_q, armed_q, status_q, status_d, en_q, en_d, rise;
  logic             irq_q;

  // armed_q: source has been seen low since reset, so a level held high
  // through reset release cannot fake a rising edge.
  always_comb begin
    rise     = irq_src & ~hist_q & armed_q;
    status_d = status_q | rise;
    en_d     = en_q;
    if (wr_en && (wr_addr == ADDR_IRQ_STAT) && be[0])
      status_d = (status_q & ~wdata[IRQ_N-1:0]) | rise;
    if (wr_en && (wr_addr == ADDR_IRQ_EN) && be[0])
      en_d = wdata[IRQ_N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      armed_q  <= ~irq_src;
      status_q <= '0;
      en_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      hist_q   <= irq_src;
      armed_q  <= armed_q | ~irq_src;
      status_q <= status_d;
      en_q     <= en_d;
      irq_q    <= |(status_q & en_q);
    end
  end

  assign irq       = irq_q;
  assign stat_rd   = status_q;
  assign en_rd     = en_q;
  assign unused_ok = ^{be, wdata, led_full};
`else
  assign irq       = 1'b0;
  assign stat_rd   = '0;
  assign en_rd     = '0;
  assign unused_ok = ^{be, wdata, led_full, irq_src};
`endif

  assign uart_send_byte = send_q;
  assign uart_send_stb  = stb_q;
  assign uart_cfg       = cfg_q;
  assign led            = led_q;
  assign rdata          = rdata_q;
  assign rd_rdy         = rd_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_periph_regs : random + directed stimulus against a register model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_periph_regs;
  localparam int LED_W  = 6;
  localparam int IRQ_N  = 4;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        uart_status, uart_rcvd_byte, uart_send_byte, uart_cfg;
  logic              uart_send_stb, irq, wr_en, rd_en, rd_rdy;
  logic [LED_W-1:0]  led;
  logic [IRQ_N-1:0]  irq_src;
  logic [3:0]        be;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wdata, rdata;

  periph_regs #(.LED_W(LED_W), .IRQ_N(IRQ_N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .uart_status(uart_status), .uart_rcvd_byte(uart_rcvd_byte),
    .uart_send_byte(uart_send_byte), .uart_send_stb(uart_send_stb),
    .uart_cfg(uart_cfg), .led(led), .irq_src(irq_src), .irq(irq),
    .wr_en(wr_en), .be(be), .wr_addr(wr_addr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_rdy(rd_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic [31:0]      rdat;
    logic             stb;
    logic [7:0]       send;
    logic [7:0]       cfg;
    logic [LED_W-1:0] led;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: register contents as software would see them.
  logic [7:0]       m_send, m_cfg;
  logic [LED_W-1:0] m_led;
  logic [IRQ_N-1:0] m_status, m_en, m_last_src, m_seen_low;

  function automatic logic [31:0] mread(input logic [15:0] a);
    case (a)
      16'h0000: return {m_cfg, uart_rcvd_byte, m_send, uart_status};
      16'h0004: return 32'(m_led);
`ifdef PERIPH_REGS_IRQ_EN
      16'h0008: return 32'(m_status);
      16'h000C: return 32'(m_en);
`endif
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge: drive inputs, predict the outputs after the edge.
  task automatic step(input logic r, input logic we, input logic [3:0] b,
                      input logic [15:0] wa, input logic [31:0] wd,
                      input logic re, input logic [15:0] ra,
                      input logic [IRQ_N-1:0] s);
    exp_t e;
    logic [31:0] full, mask;
    logic [IRQ_N-1:0] rises, clr;
    rst = r; wr_en = we; be = b; wr_addr = wa; wdata = wd;
    rd_en = re; rd_addr = ra; irq_src = s;
    if (r) begin
      m_send = 8'h00; m_cfg = 8'h06; m_led = '0; m_status = '0; m_en = '0;
      m_last_src = '0; m_seen_low = ~s;
      e.rdy = 1'b0; e.rdat = 32'h0; e.stb = 1'b0; e.irq = 1'b0;
    end else begin
      e.rdy  = re;
      e.rdat = re ? mread(ra) : 32'h0;
`ifdef PERIPH_REGS_IRQ_EN
      e.irq  = |(m_status & m_en);
`else
      e.irq  = 1'b0;
`endif
      e.stb  = we && (wa == 16'h0000) && b[1];
      if (we && wa == 16'h0000 && b[1]) m_send = wd[15:8];
      if (we && wa == 16'h0000 && b[3]) m_cfg  = wd[31:24];
      if (we && wa == 16'h0004) begin
        full = 32'(m_led);
        mask = 32'h0;
        for (int k = 0; k < 4; k++) if (b[k]) mask[8*k +: 8] = 8'hFF;
        full  = (full & ~mask) | (wd & mask);
        m_led = full[LED_W-1:0];
      end
      rises = s & ~m_last_src & m_seen_low;
      clr   = (we && wa == 16'h0008 && b[0]) ? wd[IRQ_N-1:0] : '0;
      m_status   = (m_status & ~clr) | rises;
      m_seen_low = m_seen_low | ~s;
      m_last_src = s;
      if (we && wa == 16'h000C && b[0]) m_en = wd[IRQ_N-1:0];
    end
    e.send = m_send; e.cfg = m_cfg; e.led = m_led;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic [IRQ_N-1:0] s);
    step(1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0, s);
  endtask

  task automatic rd(input logic [15:0] a, input logic [IRQ_N-1:0] s);
    step(1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, a, s);
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d,
                    input logic [IRQ_N-1:0] s);
    step(1'b0, 1'b1, b, a, d, 1'b0, 16'h0, s);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 7:    return 16'h0000;
      1:       return 16'h0004;
      2:       return 16'h0008;
      3:       return 16'h000C;
      4:       return 16'h0010;
      5:       return 16'h0020;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compare every output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_rdy", 32'(rd_rdy), 32'(e.rdy));
        chk("rdata", rdata, e.rdat);
        chk("uart_send_stb", 32'(uart_send_stb), 32'(e.stb));
        chk("uart_send_byte", 32'(uart_send_byte), 32'(e.send));
        chk("uart_cfg", 32'(uart_cfg), 32'(e.cfg));
        chk("led", 32'(led), 32'(e.led));
        chk("irq", 32'(irq), 32'(e.irq));
      end
    end
  end

  initial begin
    logic [IRQ_N-1:0] s;
    rst = 1'b1; wr_en = 1'b0; be = '0; wr_addr = '0; wdata = '0;
    rd_en = 1'b0; rd_addr = '0; irq_src = '0;
    uart_status = 8'hA5; uart_rcvd_byte = 8'h3C;
    #1;
    repeat (3) step(1'b1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0, '0);

    // Reset-value read, then UART send strobes (single and back-to-back)
    rd(16'h0000, '0);
    idle('0);
    wr(16'h0000, 4'b0010, 32'h0000_4100, '0);
    idle('0);
    idle('0);
    wr(16'h0000, 4'b0010, 32'h0000_5200, '0);
    wr(16'h0000, 4'b0010, 32'h0000_5300, '0);
    wr(16'h0000, 4'b1000, 32'h9900_0000, '0);
    idle('0);

    // LED width clipping and partial byte enables
    wr(16'h0004, 4'b0001, 32'hFFFF_FFFF, '0);
    rd(16'h0004, '0);
    wr(16'h0004, 4'b1110, 32'h0000_0000, '0);
    wr(16'h0004, 4'b0000, 32'h0000_0000, '0);
    rd(16'h0004, '0);

    // Interrupt: enable, pulse, W1C coinciding with a fresh rise
    wr(16'h000C, 4'b0001, 32'h0000_0001, '0);
    idle(4'b0001);
    idle(4'b0000);
    idle(4'b0000);
    rd(16'h0008, '0);
    wr(16'h0008, 4'b0001, 32'h0000_0001, 4'b0001);
    idle(4'b0001);
    rd(16'h0008, 4'b0001);
    wr(16'h0008, 4'b0001, 32'h0000_000F, '0);
    idle('0);
    idle('0);

    // Streaming reads including an unmapped address
    rd(16'h0000, '0);
    rd(16'h0004, '0);
    rd(16'h0020, '0);
    idle('0);

    // Same-cycle read and write to one address
    step(1'b0, 1'b1, 4'b1010, 16'h0000, 32'h1200_7700, 1'b1, 16'h0000, '0);
    rd(16'h0000, '0);

    // Reset during read and write, source held high across reset release
    rd(16'h0004, 4'b0010);
    step(1'b1, 1'b1, 4'b1111, 16'h0004, 32'hFFFF_FFFF, 1'b1, 16'h0004, 4'b0010);
    idle(4'b0010);
    idle(4'b0010);
    rd(16'h0008, 4'b0010);
    idle(4'b0000);
    idle(4'b0010);
    rd(16'h0008, 4'b0010);

    // Randomized traffic
    s = 4'b0010;
    for (int n = 0; n < 600; n++) begin
      logic r, we, re;
      uart_status    = 8'($urandom);
      uart_rcvd_byte = 8'($urandom);
      if ($urandom_range(0, 2) == 0) s = s ^ IRQ_N'($urandom);
      r  = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 1) == 0);
      re = ($urandom_range(0, 2) != 0);
      step(r, we, 4'($urandom), pick_addr(), $urandom, re, pick_addr(), s);
    end
    idle('0);
    idle('0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/periph_regs.md
PERIPH_REGS -- requirements
Module: periph_regs

Interface
REQ-001 SHALL have parameter LED_W, default 4, LED output width (1..32).
REQ-002 SHALL have parameter IRQ_N, default 4, number of interrupt sources (1..8).
REQ-003 SHALL have parameter ADDR_W, default 16, register address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 uart_status  input  8  UART status byte.
REQ-007 uart_rcvd_byte  input  8  last received UART byte.
REQ-008 uart_send_byte  output  8  byte to transmit.
REQ-009 uart_send_stb  output  1  one-cycle transmit strobe.
REQ-010 uart_cfg  output  8  UART configuration.
REQ-011 led  output  LED_W  LED drive.
REQ-012 irq_src  input  IRQ_N  level interrupt sources, synchronous to clk.
REQ-013 irq  output  1  interrupt request.
REQ-014 wr_en / be / wr_addr / wdata  input  1 / 4 / ADDR_W / 32  write port; be[n] enables wdata byte n.
REQ-015 rd_en / rd_addr  input  1 / ADDR_W  read request.
REQ-016 rdata / rd_rdy  output  32 / 1  read data and valid.

Function
REQ-017 Full-address decode; unmapped writes SHALL be ignored and unmapped reads SHALL return 0.
REQ-018 0x00: [7:0] uart_status RO; [15:8] uart_send_byte RW; [23:16] uart_rcvd_byte RO; [31:24] uart_cfg RW.
REQ-019 Write to 0x00 with be[1]=1 SHALL update uart_send_byte and assert uart_send_stb for exactly the following cycle; consecutive such writes SHALL give one strobe each.
REQ-020 0x04: [LED_W-1:0] led RW, written per enabled byte; bits at and above LED_W SHALL read 0 and ignore writes.
REQ-021 0x08: irq_status[IRQ_N-1:0], sticky; bit n SHALL set the cycle after a registered 0->1 transition of irq_src[n].
REQ-022 Write to 0x08 with be[0]=1 SHALL clear each status bit whose wdata bit is 1 (W1C); same-cycle set and clear SHALL leave the bit set.
REQ-023 0x0C: irq_en[IRQ_N-1:0] RW via be[0]; unused bits read 0.
REQ-024 irq SHALL be registered OR of (irq_status AND irq_en), one cycle after either changes.
REQ-025 Read latency SHALL be one cycle: rd_en sampled at edge N gives rd_rdy=1 and rdata valid after edge N, for one cycle per request.
REQ-026 rdata SHALL be 0 whenever rd_rdy=0; back-to-back rd_en SHALL hold rd_rdy high and update rdata every cycle.
REQ-027 Same-cycle read and write to the same address SHALL return the pre-write value.

Reset
REQ-028 rst SHALL force: uart_send_byte=0, uart_send_stb=0, uart_cfg=0x06, led=0, irq_status=0, irq_en=0, irq=0, edge-detect history=0, rdata=0, rd_rdy=0.
REQ-029 rst asserted mid-read SHALL drop rd_rdy the next cycle; a write with rst in the same cycle SHALL be discarded.
REQ-030 A source already high when rst deasserts SHALL NOT set irq_status until it falls and rises again.

Configuration
REQ-031 Macro PERIPH_REGS_IRQ_EN defined: 0x08/0x0C and irq logic SHALL exist as specified.
REQ-032 Macro PERIPH_REGS_IRQ_EN undefined: 0x08/0x0C SHALL read 0 and ignore writes, irq SHALL be tied 0, irq_src SHALL be unused, no irq flops synthesised.

Verification
REQ-033 Release rst, read 0x00 with uart_status=0xA5, uart_rcvd_byte=0x3C -> rd_rdy one cycle later, rdata=0x063C00A5.
REQ-034 Write 0x00 be=0010 wdata=0x00004100 -> uart_send_byte=0x41, one uart_send_stb pulse, uart_cfg stays 0x06.
REQ-035 LED_W=6, write 0x04 be=0001 wdata=0xFFFFFFFF -> led=0x3F; read 0x04 -> 0x0000003F.
REQ-036 irq_en=0x1, pulse irq_src[0] -> irq_status=0x1, irq=1; write 0x08 be=0001 wdata=0x1 coinciding with new irq_src[0] rise -> bit stays 1.
REQ-037 rd_en high three cycles on 0x00, 0x04, 0x20 -> rd_rdy high three cycles, third rdata=0; then rd_rdy=0, rdata=0.
REQ-038 Build without PERIPH_REGS_IRQ_EN, toggle irq_src, write 0x0C=0xF -> irq=0, reads of 0x08/0x0C return 0.
